// File: rtl/sad_candidate_scanner.sv
// Sum-of-absolute-differences scanner over a rectangular search window.
// For each candidate (row-major order) it accumulates |cur - ref| over
// BLOCK_SIZE*BLOCK_SIZE streamed pixel pairs, then reports the sum with the
// candidate coordinates for one cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; pixel input not accepted
//   S_ACCUM | accepting pixel pairs for the current candidate
//   S_EMIT  | one cycle: sad_valid, result and coordinates presented
//   S_DONE  | one cycle: done pulse after the last candidate
module sad_candidate_scanner #(
  parameter int BLOCK_SIZE  = 4,
  parameter int SEARCH_ROWS = 16,
  parameter int SEARCH_COLS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cur_pixel,
  input  logic [7:0]  ref_pixel,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [31:0] sad_out,
  output logic [7:0]  sad_row_out,
  output logic [7:0]  sad_column_out,
  output logic        sad_valid,
  output logic        busy,
  output logic        done
);

  localparam int NPIX = BLOCK_SIZE * BLOCK_SIZE;
  // A 1x1 block still needs a one-bit counter to keep widths legal.
  localparam int CW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);
  localparam logic [7:0]    LAST_ROW = 8'(SEARCH_ROWS - 1);
  localparam logic [7:0]    LAST_COL = 8'(SEARCH_COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   acc;
  logic [CW-1:0] pix_cnt;
  logic [7:0]    row;
  logic [7:0]    col;
  logic [7:0]    abs_diff;
  logic [31:0]   acc_sum;
  logic          accept;
  logic          last_pix;
  logic          last_cand;

  assign abs_diff  = (cur_pixel >= ref_pixel) ? (cur_pixel - ref_pixel)
                                              : (ref_pixel - cur_pixel);
  assign acc_sum   = acc + {24'd0, abs_diff};
  assign accept    = (state == S_ACCUM) && pixel_valid && pixel_ready;
  assign last_pix  = (pix_cnt == LAST_PIX);
  assign last_cand = (row == LAST_ROW) && (col == LAST_COL);

  // Next-state decode; start is only honoured from idle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ACCUM;
      S_ACCUM: if (accept && last_pix) state_nx = S_EMIT;
      S_EMIT:  state_nx = last_cand ? S_DONE : S_ACCUM;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and status flags, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pixel_ready <= 1'b0;
      sad_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      pixel_ready <= (state_nx == S_ACCUM);
      sad_valid   <= (state_nx == S_EMIT);
      busy        <= (state_nx != S_IDLE);
      done        <= (state_nx == S_DONE);
    end
  end

  // Accumulator, pixel/candidate counters and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc            <= '0;
      pix_cnt        <= '0;
      row            <= '0;
      col            <= '0;
      sad_out        <= '0;
      sad_row_out    <= '0;
      sad_column_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc     <= '0;
            pix_cnt <= '0;
            row     <= '0;
            col     <= '0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc     <= acc_sum;
            pix_cnt <= pix_cnt + CW'(1);
            // Capture on the final pair so the result is visible during emit.
            if (last_pix) begin
              sad_out        <= acc_sum;
              sad_row_out    <= row;
              sad_column_out <= col;
            end
          end
        end
        S_EMIT: begin
          acc     <= '0;
          pix_cnt <= '0;
          if (col == LAST_COL) begin
            col <= '0;
            row <= row + 8'd1;
          end else begin
            col <= col + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_candidate_scanner.sv
// Self-checking bench for sad_candidate_scanner: three instances with
// different block/window sizes share the pixel bus; only the selected one
// receives start. Fixed-pattern table vectors plus randomized scans.
module tb_sad_candidate_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  cur_pixel;
  logic [7:0]  ref_pixel;
  logic        pixel_valid;
  int          sel;

  logic        start_a, start_b, start_c;
  logic        pr_a, pr_b, pr_c;
  logic [31:0] so_a, so_b, so_c;
  logic [7:0]  sr_a, sr_b, sr_c;
  logic [7:0]  sc_a, sc_b, sc_c;
  logic        sv_a, sv_b, sv_c;
  logic        bz_a, bz_b, bz_c;
  logic        dn_a, dn_b, dn_c;

  logic        o_ready, o_valid, o_busy, o_done;
  logic [31:0] o_sad;
  logic [7:0]  o_row, o_col;

  int vectors = 0;
  int miscompares = 0;
  longint last_sad [3];

  always #5 clk = ~clk;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  sad_candidate_scanner #(.BLOCK_SIZE(2), .SEARCH_ROWS(2), .SEARCH_COLS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cur_pixel(cur_pixel), .ref_pixel(ref_pixel),
    .pixel_valid(pixel_valid), .pixel_ready(pr_a), .sad_out(so_a), .sad_row_out(sr_a),
    .sad_column_out(sc_a), .sad_valid(sv_a), .busy(bz_a), .done(dn_a));

  sad_candidate_scanner #(.BLOCK_SIZE(4), .SEARCH_ROWS(1), .SEARCH_COLS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cur_pixel(cur_pixel), .ref_pixel(ref_pixel),
    .pixel_valid(pixel_valid), .pixel_ready(pr_b), .sad_out(so_b), .sad_row_out(sr_b),
    .sad_column_out(sc_b), .sad_valid(sv_b), .busy(bz_b), .done(dn_b));

  sad_candidate_scanner #(.BLOCK_SIZE(3), .SEARCH_ROWS(2), .SEARCH_COLS(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .cur_pixel(cur_pixel), .ref_pixel(ref_pixel),
    .pixel_valid(pixel_valid), .pixel_ready(pr_c), .sad_out(so_c), .sad_row_out(sr_c),
    .sad_column_out(sc_c), .sad_valid(sv_c), .busy(bz_c), .done(dn_c));

  // Route the selected instance's outputs to the common observation bus.
  always_comb begin
    o_ready = pr_a; o_sad = so_a; o_row = sr_a; o_col = sc_a;
    o_valid = sv_a; o_busy = bz_a; o_done = dn_a;
    case (sel)
      1: begin
        o_ready = pr_b; o_sad = so_b; o_row = sr_b; o_col = sc_b;
        o_valid = sv_b; o_busy = bz_b; o_done = dn_b;
      end
      2: begin
        o_ready = pr_c; o_sad = so_c; o_row = sr_c; o_col = sc_c;
        o_valid = sv_c; o_busy = bz_c; o_done = dn_c;
      end
      default: ;
    endcase
  end

  function automatic int bs_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 4 : 3;
  endfunction
  function automatic int rows_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 2;
  endfunction
  function automatic int cols_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 3;
  endfunction
  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"}, o_ready, 0);
    check({tag, " valid"}, o_valid, 0);
    check({tag, " busy"},  o_busy, 0);
    check({tag, " done"},  o_done, 0);
    check({tag, " sad"},   o_sad, last_sad[sel]);
  endtask

  // mode: 0 always valid, 1 valid every other cycle, 2 random valid.
  // cur_f/ref_f < 0 selects random pixels; exp_sad < 0 disables the fixed check.
  task automatic run_scan(input int s, input int mode, input int cur_f, input int ref_f,
                          input int exp_sad, input bit poke_start);
    int n, sum, k, stall, cyc, cv, rv;
    bit v;
    n = bs_of(s) * bs_of(s);
    @(negedge clk);
    sel = s; start = 1'b1; pixel_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < rows_of(s); r++) begin
      for (int c = 0; c < cols_of(s); c++) begin
        sum = 0; k = 0; stall = 0; cyc = 0;
        while (k < n) begin
          check($sformatf("accum ready s%0d (%0d,%0d)", s, r, c), o_ready, 1);
          check($sformatf("accum valid s%0d (%0d,%0d)", s, r, c), o_valid, 0);
          check($sformatf("accum busy s%0d", s), o_busy, 1);
          check($sformatf("sad hold s%0d (%0d,%0d)", s, r, c), o_sad, last_sad[s]);
          cv = (cur_f < 0) ? int'($urandom_range(0, 255)) : cur_f;
          rv = (ref_f < 0) ? int'($urandom_range(0, 255)) : ref_f;
          case (mode)
            0: v = 1'b1;
            1: v = (cyc % 2 == 1);
            default: v = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          endcase
          cur_pixel = 8'(cv); ref_pixel = 8'(rv); pixel_valid = v;
          start = poke_start && (cyc == 1);
          if (v) begin
            sum += absd(cv, rv); k++; stall = 0;
          end else begin
            stall++;
          end
          cyc++;
          @(negedge clk);
        end
        // Emit cycle: offer a bogus pair and a start, both must be ignored.
        pixel_valid = 1'b1;
        cur_pixel = 8'($urandom_range(0, 255));
        ref_pixel = 8'($urandom_range(0, 255));
        start = poke_start;
        check($sformatf("emit valid s%0d (%0d,%0d)", s, r, c), o_valid, 1);
        check($sformatf("emit sad s%0d (%0d,%0d)", s, r, c), o_sad, sum);
        check($sformatf("emit row s%0d (%0d,%0d)", s, r, c), o_row, r);
        check($sformatf("emit col s%0d (%0d,%0d)", s, r, c), o_col, c);
        check($sformatf("emit ready s%0d", s), o_ready, 0);
        check($sformatf("emit done s%0d", s), o_done, 0);
        if (exp_sad >= 0)
          check($sformatf("emit table sad s%0d (%0d,%0d)", s, r, c), o_sad, exp_sad);
        last_sad[s] = sum;
        @(negedge clk);
        start = 1'b0;
      end
    end
    check($sformatf("done pulse s%0d", s), o_done, 1);
    check($sformatf("done busy s%0d", s), o_busy, 1);
    check($sformatf("done valid s%0d", s), o_valid, 0);
    check($sformatf("done ready s%0d", s), o_ready, 0);
    pixel_valid = 1'b1;
    start = poke_start;
    @(negedge clk);
    start = 1'b0;
    pixel_valid = 1'b0;
    check_idle($sformatf("post-done s%0d", s));
  endtask

  typedef struct {
    int sel;
    int mode;
    int cur;
    int refp;
    int exp_sad;
    bit poke;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{0, 0,  10,   3,   28, 1'b0};
    tbl[1]  = '{0, 0,   3,  10,   28, 1'b0};
    tbl[2]  = '{1, 0, 255,   0, 4080, 1'b0};
    tbl[3]  = '{0, 1,   5,   1,   16, 1'b0};
    tbl[4]  = '{0, 0,   0, 255, 1020, 1'b1};
    tbl[5]  = '{0, 0,  77,  77,    0, 1'b0};
    tbl[6]  = '{2, 0,   1,   0,    9, 1'b1};
    tbl[7]  = '{1, 1,   0, 200, 3200, 1'b0};
    tbl[8]  = '{2, 2,  -1,  -1,   -1, 1'b0};
    tbl[9]  = '{0, 2,  -1,  -1,   -1, 1'b1};
    tbl[10] = '{1, 2,  -1,  -1,   -1, 1'b1};
    tbl[11] = '{2, 1,  -1,  -1,   -1, 1'b0};

    rst_n = 1'b0; start = 1'b0; pixel_valid = 1'b0;
    cur_pixel = 8'd0; ref_pixel = 8'd0; sel = 0;
    for (int i = 0; i < 3; i++) last_sad[i] = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      check_idle($sformatf("reset s%0d", i));
      check($sformatf("reset row s%0d", i), o_row, 0);
      check($sformatf("reset col s%0d", i), o_col, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      run_scan(tbl[i].sel, tbl[i].mode, tbl[i].cur, tbl[i].refp, tbl[i].exp_sad, tbl[i].poke);

    for (int i = 0; i < 9; i++)
      run_scan(i % 3, 2, -1, -1, -1, 1'($urandom_range(0, 1)));

    // Reset in the middle of accumulation discards the partial sum.
    @(negedge clk);
    sel = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pixel_valid = 1'b1; cur_pixel = 8'd200; ref_pixel = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) last_sad[i] = 0;
    check_idle("midscan reset");
    check("midscan reset row", o_row, 0);
    check("midscan reset col", o_col, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("after release %0d", i));
    end
    pixel_valid = 1'b0;
    run_scan(0, 0, 7, 2, 20, 1'b0);

    // Single-cycle start then stall mid-block on the 1x1 window.
    run_scan(1, 2, -1, -1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
